// File: rtl/bridge_dataslot_read_arbiter_pkg.sv
// Shared types for the dataslot read arbiter.
//   dataslot_rd_status_t : completion status {timeout, err[2:0]}; all-zero means success
//   dataslot_rd_req_t    : one captured read command
//   dataslot_rd_state_e  : arbiter FSM states
package bridge_dataslot_read_arbiter_pkg;

  typedef struct packed {
    logic       timeout;
    logic [2:0] err;
  } dataslot_rd_status_t;

  typedef struct packed {
    logic [15:0] slot_id;
    logic [31:0] slot_offset;
    logic [31:0] bridge_addr;
    logic [31:0] length;
  } dataslot_rd_req_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } dataslot_rd_state_e;

  localparam dataslot_rd_status_t STATUS_TIMEOUT = '{timeout: 1'b1, err: 3'b000};

endpackage

// File: rtl/bridge_dataslot_read_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority index; the scan runs upward from here with wrap
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted bit
//   any   : at least one request present
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bridge_dataslot_read_arbiter.sv
// Shares the target_dataslot_read command channel between NUM_REQ requesters.
// Round-robin grant, host handshake (read -> ack -> done), then a one-cycle
// completion pulse with status back to the winner.
//
// Ports:
//   clk, reset_n                 bridge clock, synchronous active-low reset
//   req_valid/req_*              per-requester command, fields packed i*W +: W
//   req_ready                    one-hot pulse, request accepted and captured
//   rsp_valid/rsp_status         one-hot completion pulse and {timeout, err}
//   target_dataslot_*            command channel toward the host handler
//   busy                         high outside IDLE
//
// state     | meaning
// IDLE      | arbitrate; grant captures fields and pulses req_ready
// ISSUE     | read strobe high, waiting for ack (ack+done together -> RESPOND)
// WAIT_DONE | waiting for done
// RESPOND   | rsp_valid pulse to the granted requester, no arbitration
module bridge_dataslot_read_arbiter
  import bridge_dataslot_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_slot_id,
  input  logic [NUM_REQ*32-1:0] req_slot_offset,
  input  logic [NUM_REQ*32-1:0] req_bridge_addr,
  input  logic [NUM_REQ*32-1:0] req_length,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [3:0]            rsp_status,
  output logic                  target_dataslot_read,
  output logic [15:0]           target_dataslot_id,
  output logic [31:0]           target_dataslot_slotoffset,
  output logic [31:0]           target_dataslot_bridgeaddr,
  output logic [31:0]           target_dataslot_length,
  input  logic                  target_dataslot_ack,
  input  logic                  target_dataslot_done,
  input  logic [2:0]            target_dataslot_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  dataslot_rd_state_e  state_q, state_d;
  dataslot_rd_req_t    fields_q, req_mux;
  dataslot_rd_status_t status_q, status_d;
  logic [IDX_W-1:0]    rr_ptr_q, g_q, next_ptr;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                grant_en;
  logic                tmo;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    req_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        req_mux.slot_id     = req_slot_id[i*16 +: 16];
        req_mux.slot_offset = req_slot_offset[i*32 +: 32];
        req_mux.bridge_addr = req_bridge_addr[i*32 +: 32];
        req_mux.length      = req_length[i*32 +: 32];
      end
    end
  end

  assign next_ptr = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // Counter holds the number of elapsed ISSUE/WAIT_DONE cycles; the abort
  // edge is the one that would take it past TIMEOUT_CYCLES-1.
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    grant_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // done only counts once the command is acked; a timeout beats a lone ack
        if (target_dataslot_ack && target_dataslot_done) begin
          status_d = '{timeout: 1'b0, err: target_dataslot_err};
          state_d  = RESPOND;
        end else if (tmo) begin
          status_d = STATUS_TIMEOUT;
          state_d  = RESPOND;
        end else if (target_dataslot_ack) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (target_dataslot_done) begin
          status_d = '{timeout: 1'b0, err: target_dataslot_err};
          state_d  = RESPOND;
        end else if (tmo) begin
          status_d = STATUS_TIMEOUT;
          state_d  = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      status_q    <= '0;
      fields_q    <= '0;
      rr_ptr_q    <= '0;
      g_q         <= '0;
      req_ready_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      req_ready_q <= grant_en ? arb_grant : '0;
      if (grant_en) begin
        fields_q <= req_mux;
        g_q      <= arb_idx;
        rr_ptr_q <= next_ptr;
        cnt_q    <= '0;
      end else if ((state_q == ISSUE || state_q == WAIT_DONE) && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid  = '0;
    rsp_status = '0;
    if (state_q == RESPOND) begin
      rsp_valid[g_q] = 1'b1;
      rsp_status     = status_q;
    end
  end

  assign req_ready                  = req_ready_q;
  assign busy                       = (state_q != IDLE);
  assign target_dataslot_read       = (state_q == ISSUE);
  assign target_dataslot_id         = fields_q.slot_id;
  assign target_dataslot_slotoffset = fields_q.slot_offset;
  assign target_dataslot_bridgeaddr = fields_q.bridge_addr;
  assign target_dataslot_length     = fields_q.length;

endmodule

// File: tb/tb_bridge_dataslot_read_arbiter.sv
module tb_bridge_dataslot_read_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic          clk;
  logic          reset_n;
  logic [3:0]    req_valid;
  logic [63:0]   req_slot_id;
  logic [127:0]  req_slot_offset;
  logic [127:0]  req_bridge_addr;
  logic [127:0]  req_length;
  logic [3:0]    req_ready;
  logic [3:0]    rsp_valid;
  logic [3:0]    rsp_status;
  logic          target_dataslot_read;
  logic [15:0]   target_dataslot_id;
  logic [31:0]   target_dataslot_slotoffset;
  logic [31:0]   target_dataslot_bridgeaddr;
  logic [31:0]   target_dataslot_length;
  logic          target_dataslot_ack;
  logic          target_dataslot_done;
  logic [2:0]    target_dataslot_err;
  logic          busy;

  logic [15:0] f_id   [NREQ];
  logic [31:0] f_off  [NREQ];
  logic [31:0] f_addr [NREQ];
  logic [31:0] f_len  [NREQ];

  // reference model state
  int         exp_ptr;
  logic [3:0] pending;

  int errors;
  int checks;

  bridge_dataslot_read_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .req_valid                  (req_valid),
    .req_slot_id                (req_slot_id),
    .req_slot_offset            (req_slot_offset),
    .req_bridge_addr            (req_bridge_addr),
    .req_length                 (req_length),
    .req_ready                  (req_ready),
    .rsp_valid                  (rsp_valid),
    .rsp_status                 (rsp_status),
    .target_dataslot_read       (target_dataslot_read),
    .target_dataslot_id         (target_dataslot_id),
    .target_dataslot_slotoffset (target_dataslot_slotoffset),
    .target_dataslot_bridgeaddr (target_dataslot_bridgeaddr),
    .target_dataslot_length     (target_dataslot_length),
    .target_dataslot_ack        (target_dataslot_ack),
    .target_dataslot_done       (target_dataslot_done),
    .target_dataslot_err        (target_dataslot_err),
    .busy                       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_slot_id     = '0;
    req_slot_offset = '0;
    req_bridge_addr = '0;
    req_length      = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_slot_id[i*16 +: 16]      = f_id[i];
      req_slot_offset[i*32 +: 32]  = f_off[i];
      req_bridge_addr[i*32 +: 32]  = f_addr[i];
      req_length[i*32 +: 32]       = f_len[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // round-robin rule: first pending index at or after the pointer, wrapping
  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (((m >> ((p + k) % NREQ)) & 4'd1) != 4'd0) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic post_req(input int i);
    f_id[i]      = 16'($urandom);
    f_off[i]     = $urandom;
    f_addr[i]    = $urandom;
    f_len[i]     = $urandom;
    pending[i]   = 1'b1;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input bit keep, output int g, output int n);
    int         e;
    logic [3:0] exp_oh;
    e      = pick(pending, exp_ptr);
    exp_oh = (e >= 0) ? (4'b0001 << e) : 4'b0000;
    g      = -1;
    n      = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (req_ready !== 4'b0000) begin
        n = c;
        break;
      end
    end
    checks++;
    if (req_ready !== exp_oh || n == 0) begin
      errors++;
      $display("FAIL grant: req_ready=%b expected %b (after %0d cycles)", req_ready, exp_oh, n);
    end
    if (e >= 0) begin
      g = e;
      checks++;
      if (target_dataslot_id !== f_id[e] || target_dataslot_slotoffset !== f_off[e] ||
          target_dataslot_bridgeaddr !== f_addr[e] || target_dataslot_length !== f_len[e]) begin
        errors++;
        $display("FAIL capture[%0d]: got %h/%h/%h/%h expected %h/%h/%h/%h", e,
                 target_dataslot_id, target_dataslot_slotoffset, target_dataslot_bridgeaddr,
                 target_dataslot_length, f_id[e], f_off[e], f_addr[e], f_len[e]);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_on_grant: got %b expected 1", busy);
      end
      exp_ptr = (e + 1) % NREQ;
      if (!keep) begin
        pending[e]   = 1'b0;
        req_valid[e] = 1'b0;
      end
    end
  endtask

  // Host side of one transaction, starting in the cycle where req_ready is seen
  // (cycle 0). Ack is pulsed in cycle a, done in cycle a+d (or with ack when same).
  task automatic host_txn(input int g, input int a, input int d, input bit same,
                          input bit nodone, input logic [2:0] e);
    int         dcyc, exp_cyc, got;
    logic [3:0] exp_st, exp_oh;
    dcyc = same ? a : a + d;
    if (nodone || dcyc > TMO - 1) begin
      exp_cyc = TMO;
      exp_st  = 4'h8;
    end else begin
      exp_cyc = dcyc + 1;
      exp_st  = {1'b0, e};
    end
    exp_oh = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    got    = -1;
    for (int cyc = 0; cyc < TMO + 10; cyc++) begin
      if (rsp_valid !== 4'b0000) begin
        got = cyc;
        break;
      end
      checks++;
      if (target_dataslot_read !== 1'(cyc <= a)) begin
        errors++;
        $display("FAIL read_strobe: cycle %0d read=%b expected %b", cyc, target_dataslot_read, cyc <= a);
      end
      if (cyc == 1) begin
        checks++;
        if (req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL ready_pulse: req_ready=%b expected 0000", req_ready);
        end
      end
      target_dataslot_ack  = (cyc == a);
      target_dataslot_done = !nodone && (cyc == dcyc);
      target_dataslot_err  = (cyc == dcyc) ? e : 3'($urandom);
      tick();
    end
    target_dataslot_ack  = 1'b0;
    target_dataslot_done = 1'b0;
    target_dataslot_err  = 3'b000;
    checks++;
    if (got != exp_cyc) begin
      errors++;
      $display("FAIL rsp_latency: got cycle %0d expected %0d", got, exp_cyc);
    end
    checks++;
    if (rsp_valid !== exp_oh) begin
      errors++;
      $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_oh);
    end
    checks++;
    if (rsp_status !== exp_st) begin
      errors++;
      $display("FAIL rsp_status: got %h expected %h", rsp_status, exp_st);
    end
    checks++;
    if (target_dataslot_read !== 1'b0) begin
      errors++;
      $display("FAIL read_in_respond: got %b expected 0", target_dataslot_read);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_rsp: rsp_valid=%b busy=%b expected 0000/0", rsp_valid, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_status !== 4'h0 ||
        target_dataslot_read !== 1'b0 || target_dataslot_id !== 16'h0 ||
        target_dataslot_slotoffset !== 32'h0 || target_dataslot_bridgeaddr !== 32'h0 ||
        target_dataslot_length !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy=%b rsp=%b st=%h rd=%b id=%h off=%h addr=%h len=%h busy=%b expected all zero",
               tag, req_ready, rsp_valid, rsp_status, target_dataslot_read, target_dataslot_id,
               target_dataslot_slotoffset, target_dataslot_bridgeaddr, target_dataslot_length, busy);
    end
  endtask

  task automatic test_reset();
    reset_n              = 1'b0;
    req_valid            = 4'b0;
    pending              = 4'b0;
    exp_ptr              = 0;
    target_dataslot_ack  = 1'b0;
    target_dataslot_done = 1'b0;
    target_dataslot_err  = 3'b000;
    for (int i = 0; i < NREQ; i++) begin
      f_id[i] = '0; f_off[i] = '0; f_addr[i] = '0; f_len[i] = '0;
    end
    repeat (3) tick();
    check_all_zero("reset_state");
    reset_n = 1'b1;
    tick();
    // stray ack/done while idle must be ignored
    target_dataslot_ack  = 1'b1;
    target_dataslot_done = 1'b1;
    target_dataslot_err  = 3'b111;
    tick();
    target_dataslot_ack  = 1'b0;
    target_dataslot_done = 1'b0;
    target_dataslot_err  = 3'b000;
    tick();
    check_all_zero("ignore_idle_ack_done");
  endtask

  task automatic test_single();
    int g, n;
    f_id[2]      = 16'd3;
    f_off[2]     = 32'h0000_0100;
    f_addr[2]    = 32'h1000_0000;
    f_len[2]     = 32'h0000_0200;
    pending[2]   = 1'b1;
    req_valid[2] = 1'b1;
    wait_grant(1'b0, g, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL single_latency: req_ready after %0d cycles expected 1", n);
    end
    host_txn(g, 5, 20, 1'b0, 1'b0, 3'b000);
    checks++;
    if (target_dataslot_id !== 16'd3 || target_dataslot_bridgeaddr !== 32'h1000_0000) begin
      errors++;
      $display("FAIL hold_in_idle: id=%h addr=%h expected 0003/10000000",
               target_dataslot_id, target_dataslot_bridgeaddr);
    end
  endtask

  task automatic test_host_error();
    int g, n;
    post_req(0);
    wait_grant(1'b0, g, n);
    host_txn(g, 2, 3, 1'b0, 1'b0, 3'b101);
  endtask

  task automatic test_same_cycle();
    int g, n;
    post_req(1);
    wait_grant(1'b0, g, n);
    host_txn(g, 4, 0, 1'b1, 1'b0, 3'b011);
  endtask

  task automatic test_timeout();
    int g, n;
    post_req(3);
    wait_grant(1'b0, g, n);
    host_txn(g, 3, 0, 1'b0, 1'b1, 3'b000);
    post_req(0);
    wait_grant(1'b0, g, n);
    host_txn(g, 1, 2, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_contention();
    int g, n;
    int order [5];
    reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) post_req(i);
    tick();
    tick();
    exp_ptr = 0;
    reset_n = 1'b1;
    for (int r = 0; r < 5; r++) begin
      wait_grant(1'b1, g, n);
      order[r] = g;
      host_txn(g, 0, 0, 1'b1, 1'b0, 3'b000);
    end
    checks++;
    if (order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
      errors++;
      $display("FAIL contention_order: got %0d,%0d,%0d,%0d,%0d expected 0,1,2,3,0",
               order[0], order[1], order[2], order[3], order[4]);
    end
    req_valid = 4'b0;
    pending   = 4'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int g, n;
    post_req(1);
    wait_grant(1'b0, g, n);
    target_dataslot_ack = 1'b1;
    tick();
    target_dataslot_ack = 1'b0;
    checks++;
    if (busy !== 1'b1 || target_dataslot_read !== 1'b0) begin
      errors++;
      $display("FAIL wait_done_entry: busy=%b read=%b expected 1/0", busy, target_dataslot_read);
    end
    tick();
    reset_n = 1'b0;
    tick();
    check_all_zero("reset_mid_txn");
    reset_n = 1'b1;
    exp_ptr = 0;
    target_dataslot_done = 1'b1;
    target_dataslot_err  = 3'b010;
    tick();
    target_dataslot_done = 1'b0;
    target_dataslot_err  = 3'b000;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL late_done_ignored: rsp_valid=%b busy=%b expected 0000/0", rsp_valid, busy);
      end
      tick();
    end
    // pointer is back at 0, so index 1 must win over 2
    post_req(1);
    post_req(2);
    wait_grant(1'b0, g, n);
    host_txn(g, 1, 1, 1'b0, 1'b0, 3'b000);
    wait_grant(1'b0, g, n);
    host_txn(g, 0, 4, 1'b0, 1'b0, 3'b001);
  endtask

  task automatic test_random();
    int         g, n, a, d;
    bit         same, nodone;
    logic [3:0] add;
    for (int r = 0; r < 24; r++) begin
      add = 4'($urandom) & ~pending;
      if ((pending | add) == 4'b0) add[$urandom_range(0, 3)] = 1'b1;
      for (int i = 0; i < NREQ; i++) if (add[i]) post_req(i);
      wait_grant(1'b0, g, n);
      a      = $urandom_range(0, 6);
      d      = $urandom_range(1, 25);
      same   = ($urandom_range(0, 3) == 0);
      nodone = ($urandom_range(0, 9) == 0);
      host_txn(g, a, d, same, nodone, 3'($urandom));
    end
    while (pending != 4'b0) begin
      wait_grant(1'b0, g, n);
      host_txn(g, 0, 1, 1'b0, 1'b0, 3'b000);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_host_error();
    test_same_cycle();
    test_timeout();
    test_contention();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
